// File: rtl/lock_pkg.sv
// lock_pkg
// Shared definitions for the lock datapath: FSM state encoding, the
// ceil-log2 helper used to size digit and counter fields, and the default
// key/code geometry shared with the lock-control FSM.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEFAULT_NUM_KEYS    = 4;
    localparam int DEFAULT_CODE_LENGTH = 4;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input longint value);
        int r;
        r = 0;
        for (int i = 0; i < 62; i++) begin
            if ((longint'(1) << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// inactivity_timer
// Idle-cycle counter for a partial code entry. Counts enabled cycles since the
// last restart and raises expire_o (combinationally, for one cycle) on the
// cycle whose clock edge would bring the count to TIMEOUT_CYCLES-1, so that a
// registered consumer sees its pulse after exactly TIMEOUT_CYCLES-1 idle edges.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   restart_i  clear the count (a digit was captured)
//   hold_i     force the count to 0 (no partial entry in progress)
//   enable_i   count this cycle
//   expire_o   timeout fires at this edge
module inactivity_timer
    import lock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic hold_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int            CW   = clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] count_q, count_d;

    assign expire_o = enable_i && !restart_i && !hold_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (restart_i || hold_i || expire_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/code_entry_collector.sv
// code_entry_collector
// Turns one-hot key-press pulses into key indices, shifts them into a
// CODE_LENGTH-digit code register (first digit ends up in the MS slice) and
// hands the complete code to the lock controller with a valid/ack handshake.
// A partial entry is dropped after TIMEOUT_CYCLES-1 idle cycles.
// Ports:
//   clock_i         system clock, rising edge
//   reset_i         asynchronous active-high reset
//   keyEdge_i       one-cycle press pulses, bit i = key i
//   codeAck_i       consumer acknowledge, honoured only while holding a code
//   code_o          collected digits
//   codeValid_o     a complete code is being held
//   digitCount_o    digits captured so far
//   entryTimeout_o  one-cycle pulse when a partial entry is discarded
module code_entry_collector
    import lock_pkg::*;
#(
    parameter int NUM_KEYS       = DEFAULT_NUM_KEYS,
    parameter int CODE_LENGTH    = DEFAULT_CODE_LENGTH,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int KEY_BITS       = clog2(NUM_KEYS)
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic [NUM_KEYS-1:0]             keyEdge_i,
    input  logic                            codeAck_i,
    output logic [CODE_LENGTH*KEY_BITS-1:0] code_o,
    output logic                            codeValid_o,
    output logic [clog2(CODE_LENGTH+1)-1:0] digitCount_o,
    output logic                            entryTimeout_o
);

    localparam int CW    = CODE_LENGTH * KEY_BITS;
    localparam int CNT_W = clog2(CODE_LENGTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic                press;
    logic [KEY_BITS-1:0] digit;
    logic                tmr_restart, tmr_hold, tmr_enable, tmr_expire;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign press = (keyEdge_i != '0) &&
                   ((keyEdge_i & (keyEdge_i - NUM_KEYS'(1))) == '0);

    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keyEdge_i[i]) digit = KEY_BITS'(i);
        end
    end

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clock_i),
        .rst_i    (reset_i),
        .restart_i(tmr_restart),
        .hold_i   (tmr_hold),
        .enable_i (tmr_enable),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        count_d     = count_q;
        valid_d     = valid_q;
        timeout_d   = 1'b0;
        tmr_restart = 1'b0;
        tmr_hold    = 1'b0;
        tmr_enable  = 1'b0;

        unique case (state_q)
            IDLE, ENTRY: begin
                tmr_hold   = (state_q == IDLE);
                tmr_enable = (state_q == ENTRY);
                if (press) begin
                    // A press beats a timeout due on the same edge.
                    tmr_restart = 1'b1;
                    code_d      = (code_q << KEY_BITS) | CW'(digit);
                    count_d     = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(CODE_LENGTH - 1)) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ENTRY;
                    end
                end else if (tmr_expire) begin
                    code_d    = '0;
                    count_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            HOLD: begin
                // Keys are dropped here, including one coincident with the ack.
                tmr_hold = 1'b1;
                if (codeAck_i) begin
                    code_d  = '0;
                    count_d = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
                count_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            code_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign code_o         = code_q;
    assign codeValid_o    = valid_q;
    assign digitCount_o   = count_q;
    assign entryTimeout_o = timeout_q;

endmodule
